// File: rtl/rf68851_sys_bridge.sv
// rf68851_sys_bridge
// Registered bridge between the rf68851 MMU memory-side port and the system
// bus. A request seen in IDLE is replayed on the system bus one cycle later;
// the system response is returned to the MMU one cycle after it is sampled.
// A watchdog turns an unanswered cycle into a bus error and records its
// address in tmo_adr_o.
//
// Handshake: the MMU holds s_cyc_i/s_stb_i high until it has seen one of
// s_ack_o/s_err_o/s_vpa_o, then drops s_stb_i. The bridge holds that
// response until s_stb_i is sampled low. On the system side the bridge holds
// stb_o high until one of err_i/ack_i/vpa_i is sampled high or the watchdog
// expires. cyc_o stays high while s_cyc_i is high, so a read-modify-write
// sequence keeps the bus locked. If the MMU drops s_stb_i before the response
// arrives, the system cycle still runs to completion and its response is
// discarded.
module rf68851_sys_bridge #(
  parameter int TMO_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  s_fc_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_ios_i,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic        s_vpa_o,
  output logic [31:0] s_dat_o,
  output logic [2:0]  fc_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic        ios_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        vpa_i,
  input  logic [31:0] dat_i,
  output logic        timeout_o,
  output logic [31:0] tmo_adr_o
);

  localparam int CW = $clog2(TMO_CYCLES + 1);
  // Counter value in the last cycle stb_o may stay high unanswered.
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ack_q, s_ack_d;
  logic          s_err_q, s_err_d;
  logic          s_vpa_q, s_vpa_d;
  logic [31:0]   s_dat_q, s_dat_d;
  logic [2:0]    fc_q, fc_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          ios_q, ios_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   tmo_adr_q, tmo_adr_d;

  logic          any_rsp;
  logic          tmo_hit;
  logic          deliver;
  logic [CW-1:0] cnt_inc;

  assign any_rsp = err_i | ack_i | vpa_i;
  assign tmo_hit = (cnt_q == TMO_LAST);
  // The MMU still wants the answer only while in REQ with its strobe up.
  assign deliver = (state_q == REQ) && s_stb_i;
  // The watchdog counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  // Next-state and registered-output logic of the bridge FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_ack_d   = s_ack_q;
    s_err_d   = s_err_q;
    s_vpa_d   = s_vpa_q;
    s_dat_d   = s_dat_q;
    fc_d      = fc_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    ios_d     = ios_q;
    tmo_d     = 1'b0;
    tmo_adr_d = tmo_adr_q;

    case (state_q)
      IDLE: begin
        // A locked cycle persists only while the MMU keeps s_cyc_i high.
        cyc_d = cyc_q & s_cyc_i;
        if (s_cyc_i && s_stb_i) begin
          fc_d    = s_fc_i;
          we_d    = s_we_i;
          sel_d   = s_sel_i;
          adr_d   = s_adr_i;
          dat_d   = s_dat_i;
          ios_d   = s_ios_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ, DRAIN: begin
        cnt_d = cnt_inc;
        if (any_rsp) begin
          // A response beats a watchdog expiry in the same cycle.
          stb_d = 1'b0;
          cyc_d = s_cyc_i;
          if (deliver) begin
            s_err_d = err_i;
            s_ack_d = ~err_i & ack_i;
            s_vpa_d = ~err_i & ~ack_i & vpa_i;
            if (!err_i && ack_i && !we_q) begin
              s_dat_d = dat_i;
            end
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          stb_d     = 1'b0;
          cyc_d     = s_cyc_i;
          tmo_d     = 1'b1;
          tmo_adr_d = adr_q;
          if (deliver) begin
            s_err_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (!deliver) begin
          state_d = DRAIN;
        end
      end

      HOLD: begin
        cyc_d = cyc_q & s_cyc_i;
        if (!s_stb_i) begin
          s_ack_d = 1'b0;
          s_err_d = 1'b0;
          s_vpa_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including the
  // watchdog counter and the recorded timeout address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_ack_q   <= 1'b0;
      s_err_q   <= 1'b0;
      s_vpa_q   <= 1'b0;
      s_dat_q   <= '0;
      fc_q      <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      ios_q     <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ack_q   <= s_ack_d;
      s_err_q   <= s_err_d;
      s_vpa_q   <= s_vpa_d;
      s_dat_q   <= s_dat_d;
      fc_q      <= fc_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ios_q     <= ios_d;
      tmo_q     <= tmo_d;
      tmo_adr_q <= tmo_adr_d;
    end
  end

  assign s_ack_o   = s_ack_q;
  assign s_err_o   = s_err_q;
  assign s_vpa_o   = s_vpa_q;
  assign s_dat_o   = s_dat_q;
  assign fc_o      = fc_q;
  assign cyc_o     = cyc_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign sel_o     = sel_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign ios_o     = ios_q;
  assign timeout_o = tmo_q;
  assign tmo_adr_o = tmo_adr_q;

endmodule

// File: tb/tb_rf68851_sys_bridge.sv
// Directed bench for rf68851_sys_bridge. The stimulus thread pushes the
// expected MMU response, system request and timeout address into queues;
// monitor processes pop and compare whenever the DUT presents them.
module tb_rf68851_sys_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  s_fc_i;
  logic        s_cyc_i, s_stb_i, s_we_i, s_ios_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_adr_i, s_dat_i;
  logic        s_ack_o, s_err_o, s_vpa_o;
  logic [31:0] s_dat_o;
  logic [2:0]  fc_o;
  logic        cyc_o, stb_o, we_o, ios_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic        ack_i, err_i, vpa_i;
  logic [31:0] dat_i;
  logic        timeout_o;
  logic [31:0] tmo_adr_o;

  rf68851_sys_bridge #(.TMO_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_fc_i(s_fc_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_ios_i(s_ios_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_vpa_o(s_vpa_o), .s_dat_o(s_dat_o),
    .fc_o(fc_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .ios_o(ios_o),
    .ack_i(ack_i), .err_i(err_i), .vpa_i(vpa_i), .dat_i(dat_i),
    .timeout_o(timeout_o), .tmo_adr_o(tmo_adr_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] rsp_q[$];   // {err, ack, vpa, s_dat}
  logic [72:0] req_q[$];   // {fc, we, sel, ios, adr, dat}
  logic [31:0] tmo_q[$];

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [2:0] fc, input logic ios);
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = we;
    s_sel_i = sel;
    s_adr_i = adr;
    s_dat_i = dat;
    s_fc_i  = fc;
    s_ios_i = ios;
    req_q.push_back({fc, we, sel, ios, adr, dat});
  endtask

  // Drive a system response for one cycle; returns just after it is sampled.
  task automatic respond(input logic e, input logic a, input logic v, input logic [31:0] d);
    err_i = e;
    ack_i = a;
    vpa_i = v;
    dat_i = d;
    tick();
    err_i = 1'b0;
    ack_i = 1'b0;
    vpa_i = 1'b0;
  endtask

  task automatic end_cycle();
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    tick();
  endtask

  // ---------------- monitors ----------------
  logic        prev_rsp = 1'b0;
  logic        prev_stb = 1'b0;
  logic        any_rsp;
  logic [34:0] rsp_vec;
  logic [34:0] rsp_exp;
  logic [72:0] req_exp;
  logic [31:0] tmo_exp;

  assign any_rsp = s_ack_o | s_err_o | s_vpa_o;
  assign rsp_vec = {s_err_o, s_ack_o, s_vpa_o, s_dat_o};

  // MMU-side response monitor.
  always @(negedge clk) begin
    if (any_rsp && !prev_rsp) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", rsp_vec, 73'd0);
      end else begin
        rsp_exp = rsp_q.pop_front();
        check("mmu_rsp", rsp_vec, rsp_exp);
      end
    end
    prev_rsp = any_rsp;
  end

  // System-side request monitor.
  always @(negedge clk) begin
    if (stb_o && !prev_stb) begin
      if (req_q.size() == 0) begin
        check("unexpected_req", stb_o, 1'b0);
      end else begin
        req_exp = req_q.pop_front();
        check("sys_req", {fc_o, we_o, sel_o, ios_o, adr_o, dat_o}, req_exp);
      end
    end
    prev_stb = stb_o;
  end

  // Watchdog-expiry monitor.
  always @(negedge clk) begin
    if (timeout_o) begin
      if (tmo_q.size() == 0) begin
        check("unexpected_tmo", timeout_o, 1'b0);
      end else begin
        tmo_exp = tmo_q.pop_front();
        check("tmo_adr", tmo_adr_o, tmo_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    s_fc_i = '0; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    s_sel_i = '0; s_adr_i = '0; s_dat_i = '0; s_ios_i = 1'b0;
    ack_i = 1'b0; err_i = 1'b0; vpa_i = 1'b0; dat_i = '0;
    tick();
    tick();
    check("reset_outputs",
          {s_ack_o, s_err_o, s_vpa_o, s_dat_o, fc_o, cyc_o, stb_o, we_o, sel_o, ios_o,
           timeout_o, tmo_adr_o}, 73'd0);
    check("reset_adr_dat", {adr_o, dat_o}, 73'd0);
    rst_i = 1'b0;
    tick();

    // Read with ack three cycles into the system cycle.
    issue(1'b0, 4'hF, 32'h0010_0040, 32'h0, 3'd5, 1'b0);
    rsp_q.push_back({3'b010, 32'hDEAD_BEEF});
    check("rd_stb_before_edge", stb_o, 1'b0);
    tick();
    check("rd_stb_n1", stb_o, 1'b1);
    check("rd_cyc_n1", cyc_o, 1'b1);
    tick();
    tick();
    check("rd_no_ack_yet", s_ack_o, 1'b0);
    respond(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("rd_ack_m1", s_ack_o, 1'b1);
    check("rd_stb_drop", stb_o, 1'b0);
    check("rd_dat", s_dat_o, 32'hDEAD_BEEF);
    tick();
    tick();
    check("rd_ack_held", s_ack_o, 1'b1);
    s_stb_i = 1'b0;
    tick();
    check("rd_ack_clear", s_ack_o, 1'b0);
    check("rd_cyc_locked", cyc_o, 1'b1);
    s_cyc_i = 1'b0;
    tick();
    check("rd_cyc_drop", cyc_o, 1'b0);

    // Write: data/sel/we replayed, read data register untouched.
    issue(1'b1, 4'h3, 32'h0000_2000, 32'h1234_5678, 3'd1, 1'b1);
    rsp_q.push_back({3'b010, 32'hDEAD_BEEF});
    tick();
    check("wr_dat_o", dat_o, 32'h1234_5678);
    check("wr_sel_o", sel_o, 4'h3);
    check("wr_we_o", we_o, 1'b1);
    respond(1'b0, 1'b1, 1'b0, 32'h5555_0000);
    check("wr_ack", s_ack_o, 1'b1);
    check("wr_s_dat_kept", s_dat_o, 32'hDEAD_BEEF);
    end_cycle();

    // Watchdog: no response at all.
    issue(1'b0, 4'hF, 32'hFD07_0100, 32'h0, 3'd6, 1'b0);
    rsp_q.push_back({3'b100, 32'hDEAD_BEEF});
    tmo_q.push_back(32'hFD07_0100);
    tick();
    for (int i = 0; i < TMO; i++) begin
      check("tmo_stb_high", stb_o, 1'b1);
      check("tmo_not_early", timeout_o, 1'b0);
      tick();
    end
    check("tmo_stb_drop", stb_o, 1'b0);
    check("tmo_err", s_err_o, 1'b1);
    check("tmo_pulse", timeout_o, 1'b1);
    check("tmo_adr_latched", tmo_adr_o, 32'hFD07_0100);
    tick();
    check("tmo_pulse_end", timeout_o, 1'b0);
    check("tmo_err_held", s_err_o, 1'b1);
    end_cycle();

    // err and ack together: err wins.
    issue(1'b0, 4'hF, 32'h0000_3000, 32'h0, 3'd5, 1'b0);
    rsp_q.push_back({3'b100, 32'hDEAD_BEEF});
    tick();
    respond(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("errack_err", s_err_o, 1'b1);
    check("errack_no_ack", s_ack_o, 1'b0);
    end_cycle();

    // vpa and ack together: ack wins, read data captured.
    issue(1'b0, 4'hF, 32'h0000_3004, 32'h0, 3'd5, 1'b0);
    rsp_q.push_back({3'b010, 32'h0BAD_F00D});
    tick();
    respond(1'b0, 1'b1, 1'b1, 32'h0BAD_F00D);
    check("vpaack_ack", s_ack_o, 1'b1);
    check("vpaack_no_vpa", s_vpa_o, 1'b0);
    end_cycle();

    // vpa alone: no read data update.
    issue(1'b0, 4'hF, 32'h0000_3008, 32'h0, 3'd5, 1'b1);
    rsp_q.push_back({3'b001, 32'h0BAD_F00D});
    tick();
    respond(1'b0, 1'b0, 1'b1, 32'h1111_1111);
    check("vpa_only", s_vpa_o, 1'b1);
    check("vpa_s_dat_kept", s_dat_o, 32'h0BAD_F00D);
    end_cycle();

    // Abort: strobe drops two cycles into the system cycle.
    issue(1'b0, 4'hF, 32'h0000_4000, 32'h0, 3'd5, 1'b0);
    tick();
    tick();
    s_stb_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_stb_held", stb_o, 1'b1);
      check("abort_cyc_held", cyc_o, 1'b1);
    end
    respond(1'b0, 1'b1, 1'b0, 32'hAAAA_5555);
    check("abort_stb_drop", stb_o, 1'b0);
    check("abort_no_ack", s_ack_o, 1'b0);
    check("abort_s_dat_kept", s_dat_o, 32'h0BAD_F00D);
    tick();
    check("abort_still_no_ack", s_ack_o, 1'b0);
    check("abort_no_tmo", timeout_o, 1'b0);
    end_cycle();

    // Response on the very cycle the watchdog would expire: response wins.
    issue(1'b0, 4'hF, 32'h0000_5000, 32'h0, 3'd5, 1'b0);
    rsp_q.push_back({3'b010, 32'h600D_CAFE});
    tick();
    check("race_idle_restart", stb_o, 1'b1);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("race_stb_still_high", stb_o, 1'b1);
    respond(1'b0, 1'b1, 1'b0, 32'h600D_CAFE);
    check("race_ack", s_ack_o, 1'b1);
    check("race_no_tmo", timeout_o, 1'b0);
    check("race_tmo_adr_kept", tmo_adr_o, 32'hFD07_0100);
    end_cycle();

    // Locked read-modify-write, then reset in the middle of the write.
    issue(1'b0, 4'hF, 32'h0000_6000, 32'h0, 3'd5, 1'b0);
    rsp_q.push_back({3'b010, 32'hCAFE_0001});
    tick();
    respond(1'b0, 1'b1, 1'b0, 32'hCAFE_0001);
    check("rmw_rd_ack", s_ack_o, 1'b1);
    s_stb_i = 1'b0;
    tick();
    check("rmw_cyc_locked", cyc_o, 1'b1);
    check("rmw_gap_stb_low", stb_o, 1'b0);
    issue(1'b1, 4'hF, 32'h0000_6000, 32'h0000_00FF, 3'd5, 1'b0);
    tick();
    check("rmw_wr_stb", stb_o, 1'b1);
    check("rmw_wr_cyc", cyc_o, 1'b1);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_cyc", cyc_o, 1'b0);
    check("rst_async_stb", stb_o, 1'b0);
    check("rst_async_ack", s_ack_o, 1'b0);
    check("rst_tmo_adr", tmo_adr_o, 32'h0);
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    check("post_rst_idle", {cyc_o, stb_o, s_ack_o, s_err_o, s_vpa_o}, 73'd0);

    check("rsp_q_drained", rsp_q.size(), 73'd0);
    check("req_q_drained", req_q.size(), 73'd0);
    check("tmo_q_drained", tmo_q.size(), 73'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
